// File: rtl/cond_unit_pkg.sv
// Shared definitions for the ARM-style condition unit: condition codes, flag
// layout, flag-group write mask and helpers used by the unit and its users.
package cond_unit_pkg;

   localparam int unsigned FLAGS_W = 4;
   localparam int unsigned FLAG_N  = 3;
   localparam int unsigned FLAG_Z  = 2;
   localparam int unsigned FLAG_C  = 1;
   localparam int unsigned FLAG_V  = 0;

   typedef logic [FLAGS_W-1:0] flags_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   // Bit order matches the FlagW input: nz is bit 1, cv is bit 0.
   typedef struct packed {
      logic nz;
      logic cv;
   } flag_mask_t;

   function automatic int unsigned ctx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic flags_t merge_flags(input flags_t cur, input flags_t upd,
                                          input flag_mask_t m);
      flags_t res;
      res = cur;
      if (m.nz) begin
         res[FLAG_N] = upd[FLAG_N];
         res[FLAG_Z] = upd[FLAG_Z];
      end
      if (m.cv) begin
         res[FLAG_C] = upd[FLAG_C];
         res[FLAG_V] = upd[FLAG_V];
      end
      return res;
   endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Control-unit side bundle of the condition unit; master drives requests,
// slave (the unit) returns gated enables and flag state.
interface cond_unit_if
   import cond_unit_pkg::*;
#(
   parameter int unsigned NCTX = 2
);
   localparam int unsigned CTXW = ctx_width(NCTX);

   logic [CTXW-1:0] CtxSel;
   logic [3:0]      Cond;
   flags_t          ALUFlags;
   logic [1:0]      FlagW;
   logic            CondLatch;
   logic            FlagCommit;
   logic            FlagSave;
   logic            FlagRestore;
   logic            PCS;
   logic            NextPC;
   logic            RegW;
   logic            MemW;
   logic            PCWrite;
   logic            RegWrite;
   logic            MemWrite;
   logic            CondExQ;
   flags_t          Flags;
   logic            FlagPending;

   modport master (
      output CtxSel, Cond, ALUFlags, FlagW, CondLatch, FlagCommit, FlagSave,
             FlagRestore, PCS, NextPC, RegW, MemW,
      input  PCWrite, RegWrite, MemWrite, CondExQ, Flags, FlagPending
   );

   modport slave (
      input  CtxSel, Cond, ALUFlags, FlagW, CondLatch, FlagCommit, FlagSave,
             FlagRestore, PCS, NextPC, RegW, MemW,
      output PCWrite, RegWrite, MemWrite, CondExQ, Flags, FlagPending
   );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition check; reusable by any block holding NZCV flags.
module cond_eval
   import cond_unit_pkg::*;
(
   input  logic [3:0] i_cond,
   input  flags_t     i_flags,
   output logic       o_cond_ex_c
);
   logic w_n, w_z, w_c, w_v;

   assign w_n = i_flags[FLAG_N];
   assign w_z = i_flags[FLAG_Z];
   assign w_c = i_flags[FLAG_C];
   assign w_v = i_flags[FLAG_V];

   always_comb begin
      o_cond_ex_c = 1'b1;
      case (cond_e'(i_cond))
         COND_EQ: o_cond_ex_c = w_z;
         COND_NE: o_cond_ex_c = !w_z;
         COND_CS: o_cond_ex_c = w_c;
         COND_CC: o_cond_ex_c = !w_c;
         COND_MI: o_cond_ex_c = w_n;
         COND_PL: o_cond_ex_c = !w_n;
         COND_VS: o_cond_ex_c = w_v;
         COND_VC: o_cond_ex_c = !w_v;
         COND_HI: o_cond_ex_c = w_c & !w_z;
         COND_LS: o_cond_ex_c = !w_c | w_z;
         COND_GE: o_cond_ex_c = (w_n == w_v);
         COND_LT: o_cond_ex_c = (w_n != w_v);
         COND_GT: o_cond_ex_c = !w_z & (w_n == w_v);
         COND_LE: o_cond_ex_c = w_z | (w_n != w_v);
         default: o_cond_ex_c = 1'b1;
      endcase
   end
endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: per-context NZCV flags with shadow copies,
// optional delayed (pending) flag write with bypass, and write-enable gating.
module cond_unit
   import cond_unit_pkg::*;
#(
   parameter int unsigned NCTX        = 2,
   parameter int unsigned FLAGW_DELAY = 1
) (
   input  logic       clk,
   input  logic       reset,
   cond_unit_if.slave bus
);
   localparam int unsigned CTXW = ctx_width(NCTX);

   flags_t          r_live [NCTX];
   flags_t          r_shad [NCTX];
   flags_t          w_live_nxt [NCTX];
   flags_t          w_shad_nxt [NCTX];
   logic            r_cond_ex_q;
   logic [CTXW-1:0] r_lat_ctx;
   logic            r_pend_valid;
   flags_t          r_pend_flags;
   flag_mask_t      r_pend_mask;
   logic [CTXW-1:0] r_pend_ctx;

   logic       w_ctx_ok;
   logic       w_lat_ok;
   flags_t     w_live_sel;
   flags_t     w_eval;
   logic       w_cond_ex;
   flag_mask_t w_wmask;
   logic       w_capture;
   logic       w_commit;

   assign w_ctx_ok   = 32'(bus.CtxSel) < NCTX;
   assign w_lat_ok   = 32'(r_lat_ctx) < NCTX;
   assign w_live_sel = w_ctx_ok ? r_live[bus.CtxSel] : '0;

   // Outstanding delayed write to this context is visible to evaluation early.
   assign w_eval = (r_pend_valid && w_ctx_ok && (r_pend_ctx == bus.CtxSel))
                   ? merge_flags(w_live_sel, r_pend_flags, r_pend_mask)
                   : w_live_sel;

   cond_eval u_cond_eval (
      .i_cond      (bus.Cond),
      .i_flags     (w_eval),
      .o_cond_ex_c (w_cond_ex)
   );

   assign w_wmask   = flag_mask_t'(bus.FlagW & {2{r_cond_ex_q}});
   assign w_capture = (FLAGW_DELAY != 0) && (w_wmask != '0) && w_lat_ok;
   assign w_commit  = (FLAGW_DELAY != 0) && bus.FlagCommit && r_pend_valid;

   // Per-context next state; restore is applied last so it beats any write.
   always_comb begin
      for (int unsigned c = 0; c < NCTX; c++) begin
         w_live_nxt[c] = r_live[c];
         w_shad_nxt[c] = r_shad[c];
         if ((FLAGW_DELAY == 0) && (r_lat_ctx == CTXW'(c)))
            w_live_nxt[c] = merge_flags(r_live[c], bus.ALUFlags, w_wmask);
         if (w_commit && (r_pend_ctx == CTXW'(c)))
            w_live_nxt[c] = merge_flags(r_live[c], r_pend_flags, r_pend_mask);
         if (w_ctx_ok && (bus.CtxSel == CTXW'(c))) begin
            if (bus.FlagSave)    w_shad_nxt[c] = r_live[c];
            if (bus.FlagRestore) w_live_nxt[c] = r_shad[c];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cond_ex_q  <= 1'b0;
         r_lat_ctx    <= '0;
         r_pend_valid <= 1'b0;
         r_pend_flags <= '0;
         r_pend_mask  <= '0;
         r_pend_ctx   <= '0;
         r_live       <= '{default: '0};
         r_shad       <= '{default: '0};
      end else begin
         if (bus.CondLatch) begin
            r_cond_ex_q <= w_cond_ex;
            r_lat_ctx   <= bus.CtxSel;
         end
         r_live <= w_live_nxt;
         r_shad <= w_shad_nxt;
         // A same-cycle capture replaces the entry being committed.
         if (w_capture) begin
            r_pend_valid <= 1'b1;
            r_pend_flags <= bus.ALUFlags;
            r_pend_mask  <= w_wmask;
            r_pend_ctx   <= r_lat_ctx;
         end else if (w_commit) begin
            r_pend_valid <= 1'b0;
         end
      end
   end

   assign bus.RegWrite    = bus.RegW & r_cond_ex_q;
   assign bus.MemWrite    = bus.MemW & r_cond_ex_q;
   assign bus.PCWrite     = bus.NextPC | (bus.PCS & r_cond_ex_q);
   assign bus.CondExQ     = r_cond_ex_q;
   assign bus.Flags       = w_live_sel;
   assign bus.FlagPending = r_pend_valid;
endmodule

// File: tb/tb_cond_unit.sv
// Directed-vector bench for cond_unit: delayed-write instance (2 contexts)
// and an immediate-write instance with 3 contexts for out-of-range selects.
module tb_cond_unit;
   import cond_unit_pkg::*;

   logic clk;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   cond_unit_if #(.NCTX(2)) b ();
   cond_unit_if #(.NCTX(3)) c ();

   cond_unit #(.NCTX(2), .FLAGW_DELAY(1)) u_dut (
      .clk(clk), .reset(reset), .bus(b.slave)
   );
   cond_unit #(.NCTX(3), .FLAGW_DELAY(0)) u_dut0 (
      .clk(clk), .reset(reset), .bus(c.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Latch AL on ctx, capture v with both groups, then commit it.
   task automatic write_flags(input logic ctx, input logic [3:0] v);
      b.CtxSel = ctx; b.Cond = COND_AL; b.CondLatch = 1'b1; step(); b.CondLatch = 1'b0;
      b.ALUFlags = v; b.FlagW = 2'b11; step(); b.FlagW = 2'b00;
      b.FlagCommit = 1'b1; step(); b.FlagCommit = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      {b.CtxSel, b.ALUFlags, b.FlagW, b.CondLatch, b.FlagCommit, b.FlagSave} = '0;
      {b.FlagRestore, b.PCS, b.NextPC, b.RegW, b.MemW} = '0;
      b.Cond = COND_AL;
      {c.CtxSel, c.ALUFlags, c.FlagW, c.CondLatch, c.FlagCommit, c.FlagSave} = '0;
      {c.FlagRestore, c.PCS, c.NextPC, c.RegW, c.MemW} = '0;
      c.Cond = COND_AL;
      #1 reset = 1'b0;

      // Reset state and gating during reset
      b.NextPC = 1'b1; b.RegW = 1'b1;
      #2;
      chk("rst_pcw",   4'(b.PCWrite),     4'd1);
      chk("rst_regw",  4'(b.RegWrite),    4'd0);
      chk("rst_flags", b.Flags,           4'h0);
      chk("rst_pend",  4'(b.FlagPending), 4'd0);
      chk("rst_cexq",  4'(b.CondExQ),     4'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      b.NextPC = 1'b0; b.RegW = 1'b0;

      // Delayed write, bypass into evaluation, commit
      b.CtxSel = 1'b0; b.Cond = COND_AL; b.CondLatch = 1'b1; step(); b.CondLatch = 1'b0;
      chk("dl_cexq_al", 4'(b.CondExQ), 4'd1);
      b.ALUFlags = 4'h4; b.FlagW = 2'b11; step(); b.FlagW = 2'b00;
      chk("dl_pend",      4'(b.FlagPending), 4'd1);
      chk("dl_flags_pre", b.Flags,           4'h0);
      b.Cond = COND_EQ; b.CondLatch = 1'b1; step(); b.CondLatch = 1'b0;
      chk("dl_bypass_eq", 4'(b.CondExQ), 4'd1);
      b.FlagCommit = 1'b1; step(); b.FlagCommit = 1'b0;
      chk("dl_flags",    b.Flags,           4'h4);
      chk("dl_pend_clr", 4'(b.FlagPending), 4'd0);

      // Reset mid-operation drops the pending entry
      b.ALUFlags = 4'hF; b.FlagW = 2'b11; step(); b.FlagW = 2'b00;
      chk("rs_pend_set", 4'(b.FlagPending), 4'd1);
      reset = 1'b0; #2;
      chk("rs_pend",  4'(b.FlagPending), 4'd0);
      chk("rs_flags", b.Flags,           4'h0);
      chk("rs_cexq",  4'(b.CondExQ),     4'd0);
      reset = 1'b1;
      b.FlagCommit = 1'b1; step(); b.FlagCommit = 1'b0;
      chk("nop_commit_flags", b.Flags,           4'h0);
      chk("nop_commit_pend",  4'(b.FlagPending), 4'd0);

      // Failed condition gates every write
      b.Cond = COND_EQ; b.CondLatch = 1'b1; step(); b.CondLatch = 1'b0;
      chk("gt_cexq", 4'(b.CondExQ), 4'd0);
      b.RegW = 1'b1; b.MemW = 1'b1; b.PCS = 1'b1; b.FlagW = 2'b11; b.ALUFlags = 4'hF;
      #1;
      chk("gt_regw", 4'(b.RegWrite), 4'd0);
      chk("gt_memw", 4'(b.MemWrite), 4'd0);
      chk("gt_pcw",  4'(b.PCWrite),  4'd0);
      step();
      chk("gt_nocap",  4'(b.FlagPending), 4'd0);
      chk("gt_flags",  b.Flags,           4'h0);
      b.FlagW = 2'b00; b.Cond = COND_AL; b.CondLatch = 1'b1; step(); b.CondLatch = 1'b0;
      chk("en_regw", 4'(b.RegWrite), 4'd1);
      chk("en_memw", 4'(b.MemWrite), 4'd1);
      chk("en_pcw",  4'(b.PCWrite),  4'd1);
      b.RegW = 1'b0; b.MemW = 1'b0; b.PCS = 1'b0;

      // Independent contexts
      write_flags(1'b1, 4'h8);
      b.CtxSel = 1'b0; #1;
      chk("cx_flags0", b.Flags, 4'h0);
      b.Cond = COND_MI; b.CondLatch = 1'b1; step(); b.CondLatch = 1'b0;
      chk("cx_mi_ctx0", 4'(b.CondExQ), 4'd0);
      b.CtxSel = 1'b1; #1;
      chk("cx_flags1", b.Flags, 4'h8);
      b.CondLatch = 1'b1; step(); b.CondLatch = 1'b0;
      chk("cx_mi_ctx1", 4'(b.CondExQ), 4'd1);

      // Save, swap, restore on ctx0
      write_flags(1'b0, 4'h3);
      chk("sr_init", b.Flags, 4'h3);
      b.FlagSave = 1'b1; step(); b.FlagSave = 1'b0;
      write_flags(1'b0, 4'hC);
      chk("sr_new", b.Flags, 4'hC);
      b.FlagSave = 1'b1; b.FlagRestore = 1'b1; step(); b.FlagSave = 1'b0; b.FlagRestore = 1'b0;
      chk("sr_swap_live", b.Flags, 4'h3);
      b.FlagRestore = 1'b1; step(); b.FlagRestore = 1'b0;
      chk("sr_swap_shadow", b.Flags, 4'hC);

      // Restore beats a same-cycle commit to the same context
      b.ALUFlags = 4'h1; b.FlagW = 2'b11; step(); b.FlagW = 2'b00;
      b.FlagCommit = 1'b1; b.FlagRestore = 1'b1; step(); b.FlagCommit = 1'b0; b.FlagRestore = 1'b0;
      chk("rw_flags", b.Flags,           4'hC);
      chk("rw_pend",  4'(b.FlagPending), 4'd0);

      // Commit of old entry while a new one is captured
      b.ALUFlags = 4'h4; b.FlagW = 2'b11; step();
      b.ALUFlags = 4'h2; b.FlagCommit = 1'b1; step(); b.FlagW = 2'b00; b.FlagCommit = 1'b0;
      chk("co_flags", b.Flags,           4'h4);
      chk("co_pend",  4'(b.FlagPending), 4'd1);
      b.FlagCommit = 1'b1; step(); b.FlagCommit = 1'b0;
      chk("co_flags2", b.Flags,           4'h2);
      chk("co_pend2",  4'(b.FlagPending), 4'd0);

      // Last writer wins, with partial masks
      b.ALUFlags = 4'h9; b.FlagW = 2'b10; step();
      b.ALUFlags = 4'h5; b.FlagW = 2'b01; step(); b.FlagW = 2'b00;
      b.FlagCommit = 1'b1; step(); b.FlagCommit = 1'b0;
      chk("lw_flags", b.Flags, 4'h1);

      // Immediate-write instance: same-edge update, out-of-range context
      c.CtxSel = 2'd0; c.Cond = COND_AL; c.CondLatch = 1'b1; step(); c.CondLatch = 1'b0;
      c.ALUFlags = 4'h9; c.FlagW = 2'b11; step(); c.FlagW = 2'b00;
      chk("d0_flags", c.Flags,           4'h9);
      chk("d0_pend",  4'(c.FlagPending), 4'd0);
      c.CtxSel = 2'd3; #1;
      chk("d0_oor_read", c.Flags, 4'h0);
      c.CondLatch = 1'b1; step(); c.CondLatch = 1'b0;
      c.ALUFlags = 4'h6; c.FlagW = 2'b11; step(); c.FlagW = 2'b00;
      c.CtxSel = 2'd0; #1;
      chk("d0_oor_ctx0", c.Flags, 4'h9);
      c.CtxSel = 2'd2; #1;
      chk("d0_oor_ctx2", c.Flags, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter NCTX, default 2, meaning number of independent flag contexts (>=1).
REQ-002 Parameter FLAGW_DELAY, default 1, meaning 0 = flags written in the issuing cycle, 1 = flags held pending until FlagCommit.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 CtxSel  in  max(1,$clog2(NCTX))  context selected for condition evaluation and flag access.
REQ-006 Cond  in  4  ARM condition field.
REQ-007 ALUFlags  in  4  {N,Z,C,V} from ALU.
REQ-008 FlagW  in  2  [1]=write N,Z; [0]=write C,V.
REQ-009 CondLatch  in  1  capture condition result and context (decode state strobe).
REQ-010 FlagCommit  in  1  commit pending flags (writeback state strobe); ignored when FLAGW_DELAY=0.
REQ-011 FlagSave / FlagRestore  in  1 each  copy live flags to / from the shadow register of CtxSel.
REQ-012 PCS, NextPC, RegW, MemW  in  1 each  control-unit write requests.
REQ-013 PCWrite, RegWrite, MemWrite  out  1 each  gated write enables.
REQ-014 CondExQ  out  1  latched condition result.
REQ-015 Flags  out  4  live flags of CtxSel (pre-bypass).
REQ-016 FlagPending  out  1  a delayed flag write is outstanding.

Function
REQ-017 Evaluation flags SHALL be live flags of CtxSel, with pending N,Z and/or C,V substituted per pending mask when FlagPending=1 and pending context equals CtxSel.
REQ-018 Condition check SHALL be combinational: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL and 4'b1111 -> 1.
REQ-019 On CondLatch=1 the unit SHALL register CondEx into CondExQ and CtxSel into the latched context; otherwise both hold.
REQ-020 RegWrite = RegW & CondExQ; MemWrite = MemW & CondExQ; PCWrite = NextPC | (PCS & CondExQ); all combinational.
REQ-021 Flag-write mask = FlagW & {2{CondExQ}}, applied to the latched context.
REQ-022 FLAGW_DELAY=0: masked groups of ALUFlags SHALL load into the live flags at the same clock edge.
REQ-023 FLAGW_DELAY=1: nonzero mask SHALL capture ALUFlags, mask and latched context into the pending register and set FlagPending next cycle.
REQ-024 FLAGW_DELAY=1: FlagCommit with FlagPending=1 SHALL write the masked pending groups to the pending context's live flags and clear FlagPending; FlagCommit with FlagPending=0 is a no-op.
REQ-025 Capture with FlagPending=1 and no commit SHALL overwrite the pending entry (last writer wins).
REQ-026 Simultaneous commit and capture SHALL commit the old entry and leave the new entry pending.
REQ-027 FlagSave SHALL copy live flags of CtxSel to its shadow; FlagRestore SHALL copy shadow to live flags.
REQ-028 Both Save and Restore in one cycle SHALL swap live and shadow flags.
REQ-029 Restore and a same-cycle flag write (REQ-022/024) to the same context: restore wins, write discarded.
REQ-030 Out-of-range CtxSel (NCTX not a power of two) SHALL read flags 0 and suppress all writes.

Reset
REQ-031 While reset=0: CondExQ=0, latched context=0, all live and shadow flags=0, pending register cleared, FlagPending=0.
REQ-032 Consequently RegWrite=MemWrite=0 and PCWrite=NextPC during reset.
REQ-033 Reset mid-operation SHALL discard any pending flag write.

Structure
REQ-034 Shared package SHALL hold condition-code constants (EQ..AL), flag bit indices N=3,Z=2,C=1,V=0 and the flag-group mask type.
REQ-035 Condition check SHALL be a separate sub-module cond_eval (Cond, Flags -> CondEx), reused by other blocks.
REQ-036 Per-context storage SHALL be parameter-indexed arrays; no per-context hand instantiation.

Verification
REQ-037 Reset: hold reset=0, drive NextPC=1, RegW=1 -> PCWrite=1, RegWrite=0, Flags=0000, FlagPending=0.
REQ-038 Delay: ctx0, Cond=AL latched, ALUFlags=0100, FlagW=11 -> FlagPending=1, Flags=0000; Cond=EQ latched next cycle -> CondExQ=1 via bypass; FlagCommit -> Flags=0100, FlagPending=0.
REQ-039 Gating: ctx0 flags 0000, Cond=EQ latched, RegW=MemW=PCS=1, FlagW=11, ALUFlags=1111 -> RegWrite=MemWrite=PCWrite=0, no capture.
REQ-040 Contexts: write 1000 to ctx1, CtxSel=0 -> Flags=0000, Cond=MI gives CondEx=0; CtxSel=1 -> Flags=1000, CondEx=1.
REQ-041 Save/restore: ctx0 flags 0011, FlagSave, write 1100, FlagSave+FlagRestore -> live 0011, shadow 1100.
REQ-042 Collision: pending 0100 plus new capture 0010 with FlagCommit same cycle -> live 0100, pending 0010, FlagPending=1.
